isr_queue: RTL and testbench

Parametrised successor to the controller's single instruction register: a DEPTH-entry instruction prefetch queue with the instruction register on its output. Words fetched from M_BUS are pushed while the controller is still executing the current instruction. The controller advances ISR from the queue head, or directly from M_BUS when the queue is empty. It sits in the controller between the memory-bus read path and the instruction decoder, and adds flush (for branches), occupancy status and overflow detection.

---
 rtl/isr_queue.sv | 132 +++++++++++++
 tb/tb_isr_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/isr_queue.sv
// isr_queue: DEPTH-entry instruction prefetch queue feeding the
// instruction register, with bypass, flush and overflow tracking.
module isr_queue #(
   parameter int                 WIDTH      = 16,
   parameter int                 DEPTH      = 4,
   parameter logic [WIDTH-1:0]   INIT_VALUE = '0
) (
   input  logic                         CLK,
   input  logic                         CLR,
   input  logic                         MIS,
   input  logic [WIDTH-1:0]             M_BUS,
   input  logic                         LD,
   input  logic                         FLUSH,
   output logic [WIDTH-1:0]             ISR,
   output logic                         ISR_VALID,
   output logic                         EMPTY,
   output logic                         FULL,
   output logic [$clog2(DEPTH+1)-1:0]   COUNT,
   output logic                         OVF
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] isr_q, isr_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;

   logic             empty;
   logic             full;
   logic             pop;
   logic             push;
   logic             bypass;
   logic             wr_en;

   // Status comes only from the registered occupancy.
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_FULL);

   // Request qualification; a pop frees a slot so a full queue
   // still accepts the word fetched in the same cycle.
   assign pop    = LD & ~empty;
   assign bypass = LD & empty & MIS;
   assign push   = MIS & (~full | pop) & ~bypass;

   // Next-state for pointers, occupancy, ISR and flags.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      isr_d    = isr_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      wr_en    = 1'b0;

      if (FLUSH) begin
         // Branch taken: drop queue and fetched word, keep ISR bits.
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
         valid_d  = 1'b0;
      end else begin
         if (pop) begin
            isr_d    = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else if (bypass) begin
            isr_d   = M_BUS;
            valid_d = 1'b1;
         end else if (LD) begin
            valid_d = 1'b0;
         end

         if (push) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end

         if (MIS & ~LD & full) begin
            ovf_d = 1'b1;
         end

         if (push & ~pop) begin
            cnt_d = cnt_q + CNT_ONE;
         end else if (pop & ~push) begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end
   end

   // Control and ISR registers, cleared asynchronously.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         isr_q    <= INIT_VALUE;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         isr_q    <= isr_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   // Queue storage; contents are meaningless until written.
   always_ff @(posedge CLK) begin
      if (wr_en & ~CLR) begin
         mem_q[wr_ptr_q] <= M_BUS;
      end
   end

   assign ISR       = isr_q;
   assign ISR_VALID = valid_q;
   assign EMPTY     = empty;
   assign FULL      = full;
   assign COUNT     = cnt_q;
   assign OVF       = ovf_q;

endmodule

// File: tb/tb_isr_queue.sv
// tb_isr_queue: directed vector table, async reset check and
// randomized run against a queue-based reference model.
module tb_isr_queue;

   localparam int W = 16;
   localparam int D = 4;
   localparam logic [W-1:0] INIT = 16'h00FF;

   logic          CLK = 1'b0;
   logic          CLR = 1'b0;
   logic          MIS = 1'b0;
   logic [W-1:0]  M_BUS = '0;
   logic          LD = 1'b0;
   logic          FLUSH = 1'b0;
   logic [W-1:0]  ISR;
   logic          ISR_VALID;
   logic          EMPTY;
   logic          FULL;
   logic [2:0]    COUNT;
   logic          OVF;

   int n_checks = 0;
   int n_fail   = 0;

   isr_queue #(
      .WIDTH(W),
      .DEPTH(D),
      .INIT_VALUE(INIT)
   ) dut (
      .CLK(CLK),
      .CLR(CLR),
      .MIS(MIS),
      .M_BUS(M_BUS),
      .LD(LD),
      .FLUSH(FLUSH),
      .ISR(ISR),
      .ISR_VALID(ISR_VALID),
      .EMPTY(EMPTY),
      .FULL(FULL),
      .COUNT(COUNT),
      .OVF(OVF)
   );

   always #5 CLK = ~CLK;

   // Reference model: plain queue plus ISR and flags.
   logic [W-1:0] mq[$];
   logic [W-1:0] m_isr;
   logic         m_valid;
   logic         m_ovf;

   task automatic model_reset();
      mq.delete();
      m_isr   = INIT;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
   endtask

   task automatic model_step(input logic mis, input logic [W-1:0] bus,
                             input logic ld, input logic fl);
      if (fl) begin
         mq.delete();
         m_valid = 1'b0;
      end else if (ld) begin
         if (mq.size() > 0) begin
            m_isr   = mq.pop_front();
            m_valid = 1'b1;
            if (mis) mq.push_back(bus);
         end else if (mis) begin
            m_isr   = bus;
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
      end else if (mis) begin
         if (mq.size() < D) mq.push_back(bus);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [W-1:0] e_isr,
                          input logic e_v, input logic [2:0] e_c,
                          input logic e_ovf);
      chk({tag, " ISR"}, 32'(ISR), 32'(e_isr));
      chk({tag, " ISR_VALID"}, 32'(ISR_VALID), 32'(e_v));
      chk({tag, " COUNT"}, 32'(COUNT), 32'(e_c));
      chk({tag, " EMPTY"}, 32'(EMPTY), 32'(e_c == 3'd0));
      chk({tag, " FULL"}, 32'(FULL), 32'(e_c == 3'(D)));
      chk({tag, " OVF"}, 32'(OVF), 32'(e_ovf));
   endtask

   task automatic cyc(input logic mis, input logic [W-1:0] bus,
                      input logic ld, input logic fl);
      MIS   = mis;
      M_BUS = bus;
      LD    = ld;
      FLUSH = fl;
      @(posedge CLK);
      #1;
      model_step(mis, bus, ld, fl);
   endtask

   typedef struct {
      logic         mis;
      logic [W-1:0] bus;
      logic         ld;
      logic         fl;
      logic [W-1:0] isr;
      logic         v;
      logic [2:0]   cnt;
      logic         ovf;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic mis, input logic [W-1:0] bus,
                      input logic ld, input logic fl,
                      input logic [W-1:0] isr, input logic v,
                      input logic [2:0] cnt, input logic ovf);
      vec_t e;
      e.mis = mis; e.bus = bus; e.ld = ld; e.fl = fl;
      e.isr = isr; e.v = v; e.cnt = cnt; e.ovf = ovf;
      tbl.push_back(e);
   endtask

   initial begin
      // Fill, overflow, push+pop at full, drain, bypass, empty load.
      add(1, 16'hA001, 0, 0, 16'h00FF, 0, 1, 0);
      add(1, 16'hA002, 0, 0, 16'h00FF, 0, 2, 0);
      add(1, 16'hA003, 0, 0, 16'h00FF, 0, 3, 0);
      add(1, 16'hA004, 0, 0, 16'h00FF, 0, 4, 0);
      add(1, 16'hBEEF, 0, 0, 16'h00FF, 0, 4, 1);
      add(1, 16'hC005, 1, 0, 16'hA001, 1, 4, 1);
      add(0, 16'h0000, 1, 0, 16'hA002, 1, 3, 1);
      add(0, 16'h0000, 1, 0, 16'hA003, 1, 2, 1);
      add(0, 16'h0000, 1, 0, 16'hA004, 1, 1, 1);
      add(0, 16'h0000, 1, 0, 16'hC005, 1, 0, 1);
      add(1, 16'h1234, 1, 0, 16'h1234, 1, 0, 1);
      add(0, 16'h0000, 1, 0, 16'h1234, 0, 0, 1);
      add(1, 16'h5555, 0, 1, 16'h1234, 0, 0, 1);
      // Wrap-around then flush with a fetch in flight.
      add(1, 16'hB001, 0, 0, 16'h1234, 0, 1, 1);
      add(1, 16'hB002, 0, 0, 16'h1234, 0, 2, 1);
      add(1, 16'hB003, 0, 0, 16'h1234, 0, 3, 1);
      add(0, 16'h0000, 1, 0, 16'hB001, 1, 2, 1);
      add(0, 16'h0000, 1, 0, 16'hB002, 1, 1, 1);
      add(1, 16'hB004, 0, 0, 16'hB002, 1, 2, 1);
      add(1, 16'hB005, 0, 0, 16'hB002, 1, 3, 1);
      add(1, 16'hB006, 0, 0, 16'hB002, 1, 4, 1);
      add(1, 16'h9999, 0, 1, 16'hB002, 0, 0, 1);
      add(1, 16'h7777, 0, 0, 16'hB002, 0, 1, 1);
      add(0, 16'h0000, 1, 0, 16'h7777, 1, 0, 1);

      // Power-on reset.
      CLR = 1'b1;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      CLR = 1'b0;
      chk_all("reset", INIT, 1'b0, 3'd0, 1'b0);

      foreach (tbl[i]) begin
         cyc(tbl[i].mis, tbl[i].bus, tbl[i].ld, tbl[i].fl);
         chk_all($sformatf("vec%0d", i), tbl[i].isr, tbl[i].v,
                 tbl[i].cnt, tbl[i].ovf);
      end

      // Mid-cycle async reset with words queued and OVF set.
      cyc(1, 16'hD001, 0, 0);
      cyc(1, 16'hD002, 0, 0);
      MIS = 1'b1;
      M_BUS = 16'hD003;
      #3;
      CLR = 1'b1;
      #1;
      model_reset();
      chk_all("async_clr", INIT, 1'b0, 3'd0, 1'b0);
      @(posedge CLK);
      #1;
      chk_all("clr_held", INIT, 1'b0, 3'd0, 1'b0);
      CLR = 1'b0;
      MIS = 1'b0;

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         logic mis, ld, fl;
         logic [W-1:0] bus;
         mis = ($urandom_range(99) < 60);
         ld  = ($urandom_range(99) < 40);
         fl  = ($urandom_range(99) < 4);
         bus = W'($urandom);
         cyc(mis, bus, ld, fl);
         chk_all("rand", m_isr, m_valid, 3'(mq.size()), m_ovf);
         if (n_fail > 20) break;
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
